ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one s_ram instance (write port + async read port) between two requesters, A and B.
//  Arbitration is round-robin. Each access is one request/grant transaction.
//  Registers the command, drives the RAM ports glitch-free, and returns read data.
//  Sits between the s_ram instance and the two client blocks. Clients never touch the RAM directly.
// PARAMETERS
//  AW  5  address width; RAM depth is 2**AW words
//  DW  4  data width of one RAM word
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  a_req      in   1   A requests an access; held high until a_gnt
//  a_we       in   1   1 = write, 0 = read; held stable while a_req=1
//  a_addr     in   AW  A target address; held stable while a_req=1
//  a_wdata    in   DW  A write data; held stable while a_req=1
//  a_gnt      out  1   one-cycle pulse: A transaction complete
//  a_rvalid   out  1   one-cycle pulse with a_gnt when A's op was a read
//  a_rdata    out  DW  A read data; valid at a_rvalid, held until A's next read
//  b_*        --   --  seven ports identical to a_*, for requester B
//  ram_raddr  out  AW  to s_ram read_addr
//  ram_waddr  out  AW  to s_ram write_addr
//  ram_wdata  out  DW  to s_ram wr_data
//  ram_wr_en  out  1   to s_ram wr_enable (level-sensitive write)
//  ram_rdata  in   DW  from s_ram read_data (combinational)
//  busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset
//   - All outputs are 0. state=IDLE. last_gnt=B, so A wins the first tie.
//   - Reset is async: ram_wr_en falls the instant rst_n falls.
//  FSM (all outputs registered): IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles.
//  IDLE
//   - No req: stay in IDLE.
//   - Exactly one req: select that requester.
//   - Both req: select the one != last_grant.
//   - On selection: latch sel, we, addr and wdata into cmd regs.
//   - Load ram_raddr, ram_waddr and ram_wdata from cmd. ram_wr_en stays 0. Go to ACCESS.
//  ACCESS
//   - ram_wr_en = cmd_we for exactly this one cycle.
//   - Address and data are already stable one cycle before ram_wr_en rises.
//   - Go to RESP.
//  RESP
//   - ram_wr_en=0. ram_waddr, ram_wdata and ram_raddr held unchanged, so the write closes cleanly.
//   - Pulse gnt[sel]. If read: capture ram_rdata into rdata[sel] and pulse rvalid[sel].
//   - last_grant <= sel. Go to IDLE.
//  Latency: request seen high at edge N -> gnt pulse high during cycle N+2.
//  RAM address/data outputs otherwise hold their last value; they never change while ram_wr_en=1.
//  Requests are sampled only in IDLE. A req that drops before gnt after selection is still completed.
//  Any AW-bit address is legal; there is no range check and no wrap logic.
//  Read-after-write to the same address from the other requester returns the new data.
//  Reset mid-transaction
//   - The transaction is aborted: no gnt or rvalid.
//   - A write in ACCESS leaves the target word undefined.
//  Fairness: a continuously requesting pair is served in strict alternation (A,B,A,B...).
// TESTING
//  1 Reset, all req=0 -> every output 0, busy=0; after release, idle cycles give no gnt and ram_wr_en=0.
//  2 A write addr=0, data=1010 -> ram_wr_en high exactly 1 cycle with waddr=0, wdata=1010;
//    a_gnt 2 cycles after req, a_rvalid=0.
//  3 B read addr=0 after test 2 -> b_gnt and b_rvalid pulse together, b_rdata=1010; a_rdata unchanged.
//  4 a_req and b_req rise together and are held -> grants A,B,A,B, each 3 cycles apart.
//    Then A drops; B alone -> consecutive B grants.
//  5 A write addr=31, data=1111, then A read addr=31 -> a_rdata=1111.
//    Also check ram_waddr/ram_wdata stable for the whole cycle around ram_wr_en.
//  6 rst_n low during ACCESS of a write -> ram_wr_en falls asynchronously, no a_gnt.
//    After release: state IDLE, A wins the next tie.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one s_ram (write port + async read port) between requesters A and B.
// Each transaction runs IDLE -> ACCESS -> RESP. All outputs are registered, so the RAM is driven glitch-free.
module ram_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_raddr,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wr_en,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sel;        // 0 = A, 1 = B
  logic          r_we;
  logic          r_last;       // last granted requester, 1 = B
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_wr_en;
  logic          r_a_gnt;
  logic          r_a_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic          r_b_gnt;
  logic          r_b_rvalid;
  logic [DW-1:0] r_b_rdata;
  logic          r_busy;

  logic          w_take;
  logic          w_sel;
  logic          w_wr_en;
  logic          w_a_gnt;
  logic          w_b_gnt;
  logic          w_a_rvalid;
  logic          w_b_rvalid;
  logic          w_busy;

  // Registers address/data ahead of the write strobe; a single address drives both RAM ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_last     <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wr_en    <= 1'b0;
      r_a_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_gnt    <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wr_en    <= w_wr_en;
      r_a_gnt    <= w_a_gnt;
      r_a_rvalid <= w_a_rvalid;
      r_b_gnt    <= w_b_gnt;
      r_b_rvalid <= w_b_rvalid;
      r_busy     <= w_busy;
      if (w_take) begin
        r_sel   <= w_sel;
        r_we    <= w_sel ? b_we    : a_we;
        r_addr  <= w_sel ? b_addr  : a_addr;
        r_wdata <= w_sel ? b_wdata : a_wdata;
      end
      if (r_state == S_RESP) r_last <= r_sel;
      if (w_a_rvalid) r_a_rdata <= ram_rdata;
      if (w_b_rvalid) r_b_rdata <= ram_rdata;
    end
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_sel  = ~r_last;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_take = 1'b1;
          w_next = S_ACCESS;
          if (a_req && !b_req)      w_sel = 1'b0;
          else if (b_req && !a_req) w_sel = 1'b1;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en    = (r_state == S_ACCESS) & r_we;
    w_a_gnt    = (r_state == S_RESP) & ~r_sel;
    w_b_gnt    = (r_state == S_RESP) &  r_sel;
    w_a_rvalid = w_a_gnt & ~r_we;
    w_b_rvalid = w_b_gnt & ~r_we;
    w_busy     = (w_next != S_IDLE);
  end

  assign a_gnt     = r_a_gnt;
  assign a_rvalid  = r_a_rvalid;
  assign a_rdata   = r_a_rdata;
  assign b_gnt     = r_b_gnt;
  assign b_rvalid  = r_b_rvalid;
  assign b_rdata   = r_b_rdata;
  assign ram_raddr = r_addr;
  assign ram_waddr = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_wr_en = r_wr_en;
  assign busy      = r_busy;

endmodule
